// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC next-address sequencer: state encoding and default vectors.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    START   = 2'd0,
    RUN     = 2'd1,
    STALLED = 2'd2,
    HALTED  = 2'd3
  } seq_state_e;

  localparam int          ADDR_W_DEF       = 16;
  localparam logic [15:0] RESET_VECTOR_DEF = 16'h0000;
  localparam logic [15:0] IRQ_VECTOR_DEF   = 16'h0004;
  localparam int          PC_INC_DEF       = 2;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bus between the pipeline control (master) and the PC sequencer (slave).
import pc_sequencer_pkg::*;

interface pc_sequencer_if #(
  parameter int ADDR_W = ADDR_W_DEF
);

  logic [ADDR_W-1:0] currentPC;
  logic              stall;
  logic              halt;
  logic              jump;
  logic [ADDR_W-1:0] jumpTarget;
  logic              branchTaken;
  logic [ADDR_W-1:0] branchTarget;
  logic              rfi;
  logic              irqReq;
  logic              irqAck;
  logic              pcWrite;
  logic [ADDR_W-1:0] nextAddress;
  logic              flush;
  logic [ADDR_W-1:0] savedPC;

  modport master (
    output currentPC, stall, halt, jump, jumpTarget, branchTaken, branchTarget, rfi, irqReq,
    input  irqAck, pcWrite, nextAddress, flush, savedPC
  );

  modport slave (
    input  currentPC, stall, halt, jump, jumpTarget, branchTaken, branchTarget, rfi, irqReq,
    output irqAck, pcWrite, nextAddress, flush, savedPC
  );

endinterface

// File: rtl/pc_sequencer.sv
// Next-address controller for the programCounter: sequential/branch/jump/interrupt selection,
// redirect buffering across stalls. Define PC_SEQ_IRQ_EN to build the interrupt entry/return path.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                ADDR_W       = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(RESET_VECTOR_DEF),
  parameter logic [ADDR_W-1:0] IRQ_VECTOR   = ADDR_W'(IRQ_VECTOR_DEF),
  parameter int                PC_INC       = PC_INC_DEF
) (
  input logic           clock,
  input logic           reset_n,
  pc_sequencer_if.slave bus
);

  seq_state_e        state;
  seq_state_e        state_d;
  logic              pending;
  logic [ADDR_W-1:0] pending_target;
  logic [ADDR_W-1:0] saved_pc;
  logic              irq_enable;

  logic              redirect_req;
  logic [ADDR_W-1:0] rfi_target;
  logic [ADDR_W-1:0] redirect_target;
  logic [ADDR_W-1:0] seq_addr;
  logic [ADDR_W-1:0] run_addr;
  logic              irq_run;

  logic              pc_write;
  logic              do_flush;
  logic              irq_ack;
  logic [ADDR_W-1:0] next_addr;
  logic              capture;
  logic              drain;
  logic              take_irq;
  logic [ADDR_W-1:0] saved_d;
  logic              rfi_done;

`ifdef PC_SEQ_IRQ_EN
  assign irq_run     = bus.irqReq & irq_enable;
  assign rfi_target  = saved_pc;
  assign bus.savedPC = saved_pc;
`else
  // Without the interrupt path rfi degrades to a jump to address zero.
  assign irq_run     = 1'b0;
  assign rfi_target  = '0;
  assign bus.savedPC = '0;
  wire unused_irq = bus.irqReq ^ irq_enable ^ (^saved_pc);
`endif

  assign seq_addr        = bus.currentPC + ADDR_W'(PC_INC);
  assign redirect_req    = bus.rfi | bus.jump | bus.branchTaken;
  assign redirect_target = bus.rfi  ? rfi_target :
                           bus.jump ? bus.jumpTarget : bus.branchTarget;
  assign run_addr        = redirect_req ? redirect_target : seq_addr;

  always_comb begin
    pc_write  = 1'b0;
    do_flush  = 1'b0;
    irq_ack   = 1'b0;
    next_addr = bus.currentPC;
    state_d   = state;
    capture   = 1'b0;
    drain     = 1'b0;
    take_irq  = 1'b0;
    saved_d   = saved_pc;
    rfi_done  = 1'b0;
    if (!reset_n) begin
      next_addr = RESET_VECTOR;
      state_d   = START;
    end else begin
      case (state)
        START: begin
          pc_write  = 1'b1;
          next_addr = RESET_VECTOR;
          state_d   = RUN;
        end
        // A stalled cycle with the stall released behaves as RUN, except that a buffered redirect wins.
        RUN, STALLED: begin
          if (bus.stall) begin
            state_d  = STALLED;
            capture  = redirect_req & ~pending;
            rfi_done = bus.rfi & ~pending;
          end else if (pending) begin
            pc_write  = 1'b1;
            do_flush  = 1'b1;
            next_addr = pending_target;
            drain     = 1'b1;
            state_d   = RUN;
          end else if (bus.halt) begin
            state_d = HALTED;
          end else if (irq_run) begin
            pc_write  = 1'b1;
            do_flush  = 1'b1;
            irq_ack   = 1'b1;
            next_addr = IRQ_VECTOR;
            take_irq  = 1'b1;
            saved_d   = run_addr;
            state_d   = RUN;
          end else begin
            pc_write  = 1'b1;
            do_flush  = redirect_req;
            next_addr = run_addr;
            rfi_done  = bus.rfi;
            state_d   = RUN;
          end
        end
        HALTED: begin
          if (irq_run) begin
            pc_write  = 1'b1;
            do_flush  = 1'b1;
            irq_ack   = 1'b1;
            next_addr = IRQ_VECTOR;
            take_irq  = 1'b1;
            saved_d   = seq_addr;
            state_d   = RUN;
          end
        end
        default: state_d = START;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state          <= START;
      pending        <= 1'b0;
      pending_target <= '0;
      saved_pc       <= '0;
      irq_enable     <= 1'b1;
    end else begin
      state <= state_d;
      if (capture) begin
        pending        <= 1'b1;
        pending_target <= redirect_target;
      end else if (drain) begin
        pending <= 1'b0;
      end
      if (take_irq) begin
        saved_pc   <= saved_d;
        irq_enable <= 1'b0;
      end else if (rfi_done) begin
        irq_enable <= 1'b1;
      end
    end
  end

  assign bus.pcWrite     = pc_write;
  assign bus.flush       = do_flush;
  assign bus.irqAck      = irq_ack;
  assign bus.nextAddress = next_addr;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table followed by randomized traffic
// checked against a behavioural model. Honours PC_SEQ_IRQ_EN for the interrupt expectations.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

`ifdef PC_SEQ_IRQ_EN
  localparam bit IRQ_BUILD = 1'b1;
`else
  localparam bit IRQ_BUILD = 1'b0;
`endif

  typedef struct {
    logic        rst_n;
    logic        set_pc;
    logic [15:0] pc_val;
    logic        stall;
    logic        halt;
    logic        jump;
    logic [15:0] jt;
    logic        br;
    logic [15:0] bt;
    logic        rfi;
    logic        irq;
    logic        e_pw;
    logic        e_fl;
    logic        e_ack;
    logic [15:0] e_na;
    logic        chk_saved;
    logic [15:0] e_saved;
  } vec_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  pc_sequencer_if #(.ADDR_W(16)) bus();

  pc_sequencer #(
    .ADDR_W(16), .RESET_VECTOR(16'h0000), .IRQ_VECTOR(16'h0004), .PC_INC(2)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus)
  );

  int compared = 0;
  int mismatched = 0;
  vec_t vecs[$];

  // Model state: nothing more than "has started", "is halted", a one-deep redirect queue and the irq registers.
  bit          m_started = 0;
  bit          m_halted = 0;
  logic [15:0] m_pend[$];
  logic [15:0] m_saved = 16'h0000;
  bit          m_en = 1;
  logic        m_pw, m_fl, m_ack;
  logic [15:0] m_na;

  function automatic vec_t mk(input logic rst_n, stall, halt, jump, input logic [15:0] jt,
                              input logic br, input logic [15:0] bt, input logic rfi, irq,
                              input logic e_pw, e_fl, e_ack, input logic [15:0] e_na);
    vec_t v;
    v.rst_n = rst_n; v.set_pc = 1'b0; v.pc_val = 16'h0000;
    v.stall = stall; v.halt = halt; v.jump = jump; v.jt = jt; v.br = br; v.bt = bt;
    v.rfi = rfi; v.irq = irq;
    v.e_pw = e_pw; v.e_fl = e_fl; v.e_ack = e_ack; v.e_na = e_na;
    v.chk_saved = 1'b0; v.e_saved = 16'h0000;
    return v;
  endfunction

  function automatic vec_t idl(input logic e_pw, e_fl, input logic [15:0] e_na);
    return mk(1, 0, 0, 0, 16'h0, 0, 16'h0, 0, 0, e_pw, e_fl, 0, e_na);
  endfunction

  task automatic check1(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    reset_n = v.rst_n;
    if (v.set_pc) bus.currentPC = v.pc_val;
    bus.stall        = v.stall;
    bus.halt         = v.halt;
    bus.jump         = v.jump;
    bus.jumpTarget   = v.jt;
    bus.branchTaken  = v.br;
    bus.branchTarget = v.bt;
    bus.rfi          = v.rfi;
    bus.irqReq       = v.irq;
  endtask

  task automatic checkOutput(input string tag, input logic e_pw, e_fl, e_ack, input logic [15:0] e_na);
    check1({tag, ".pcWrite"}, {15'h0, bus.pcWrite}, {15'h0, e_pw});
    check1({tag, ".flush"},   {15'h0, bus.flush},   {15'h0, e_fl});
    check1({tag, ".irqAck"},  {15'h0, bus.irqAck},  {15'h0, e_ack});
    if (e_pw) check1({tag, ".nextAddress"}, bus.nextAddress, e_na);
  endtask

  task automatic takeIrq(input logic [15:0] ret);
    m_pw = 1; m_fl = 1; m_ack = 1; m_na = 16'h0004;
    m_saved = ret; m_en = 0;
  endtask

  // Computes this cycle's expected outputs from the driven inputs and advances the model.
  task automatic modelStep();
    logic [15:0] rfi_t, alt, inc;
    m_pw = 0; m_fl = 0; m_ack = 0; m_na = 16'h0000;
    rfi_t = IRQ_BUILD ? m_saved : 16'h0000;
    inc   = bus.currentPC + 16'd2;
    if (!reset_n) begin
      m_started = 0; m_halted = 0; m_pend.delete(); m_saved = 16'h0000; m_en = 1;
    end else if (!m_started) begin
      m_pw = 1; m_started = 1;
    end else if (m_halted) begin
      if (IRQ_BUILD && bus.irqReq && m_en) begin
        takeIrq(inc);
        m_halted = 0;
      end
    end else if (bus.stall) begin
      if (m_pend.size() == 0 && (bus.rfi || bus.jump || bus.branchTaken)) begin
        m_pend.push_back(bus.rfi ? rfi_t : bus.jump ? bus.jumpTarget : bus.branchTarget);
        if (bus.rfi) m_en = 1;
      end
    end else if (m_pend.size() != 0) begin
      m_pw = 1; m_fl = 1; m_na = m_pend.pop_front();
    end else if (bus.halt) begin
      m_halted = 1;
    end else begin
      alt = bus.rfi ? rfi_t : bus.jump ? bus.jumpTarget : bus.branchTaken ? bus.branchTarget : inc;
      if (IRQ_BUILD && bus.irqReq && m_en) begin
        takeIrq(alt);
      end else begin
        m_pw = 1; m_na = alt;
        m_fl = bus.rfi | bus.jump | bus.branchTaken;
        if (bus.rfi) m_en = 1;
      end
    end
  endtask

  task automatic runCycle(input vec_t v, input bit use_table, input string tag);
    logic        pw;
    logic [15:0] na;
    applyStimulus(v);
    @(negedge clock);
    if (use_table) begin
      if (v.chk_saved) check1({tag, ".savedPC"}, bus.savedPC, v.e_saved);
    end else begin
      check1({tag, ".savedPC"}, bus.savedPC, m_saved);
    end
    modelStep();
    if (use_table) begin
      checkOutput(tag, v.e_pw, v.e_fl, v.e_ack, v.e_na);
      pw = v.e_pw; na = v.e_na;
    end else begin
      checkOutput(tag, m_pw, m_fl, m_ack, m_na);
      pw = m_pw; na = m_na;
    end
    @(posedge clock);
    #1;
    if (pw) bus.currentPC = na;
  endtask

  initial begin
    vec_t v;
    bus.currentPC = 16'hAAAA;
    applyStimulus(mk(0, 0, 0, 0, 16'h0, 0, 16'h0, 0, 0, 0, 0, 0, 16'h0));

    vecs.push_back(mk(0, 0, 0, 0, 16'h0, 0, 16'h0, 0, 0, 0, 0, 0, 16'h0000));
    vecs.push_back(idl(1, 0, 16'h0000));
    vecs.push_back(idl(1, 0, 16'h0002));
    vecs.push_back(idl(1, 0, 16'h0004));
    vecs.push_back(mk(1, 0, 0, 1, 16'h1234, 1, 16'h5678, 0, 0, 1, 1, 0, 16'h1234));
    vecs.push_back(idl(1, 0, 16'h1236));
    vecs.push_back(mk(1, 1, 0, 0, 16'h0, 1, 16'h0100, 0, 0, 0, 0, 0, 16'h0));
    vecs.push_back(mk(1, 1, 0, 1, 16'h0200, 0, 16'h0, 0, 0, 0, 0, 0, 16'h0));
    vecs.push_back(mk(1, 1, 0, 0, 16'h0, 0, 16'h0, 0, 0, 0, 0, 0, 16'h0));
    vecs.push_back(idl(1, 1, 16'h0100));
    vecs.push_back(idl(1, 0, 16'h0102));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0, 1, 16'h0300, 0, 0, 1, 1, 0, 16'h0300));
    vecs.push_back(mk(1, 1, 0, 0, 16'h0, 0, 16'h0, 1, 0, 0, 0, 0, 16'h0));
    vecs.push_back(mk(1, 0, 0, 1, 16'h0500, 0, 16'h0, 0, 0, 1, 1, 0, 16'h0000));
    vecs.push_back(mk(1, 0, 1, 0, 16'h0, 0, 16'h0, 0, 0, 0, 0, 0, 16'h0));
    vecs.push_back(idl(0, 0, 16'h0));
    vecs.push_back(mk(1, 0, 0, 1, 16'h0700, 0, 16'h0, 0, 0, 0, 0, 0, 16'h0));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0, 0, 16'h0, 0, 0, 0, 0, 0, 16'h0000));
    vecs.push_back(idl(1, 0, 16'h0000));
    vecs.push_back(idl(1, 0, 16'h0002));
    v = idl(1, 0, 16'h0000); v.set_pc = 1; v.pc_val = 16'hFFFE; vecs.push_back(v);
    vecs.push_back(idl(1, 0, 16'h0002));
    // Interrupt entry, held request, second request before rfi, return, re-entry.
    v = mk(1, 0, 0, 0, 16'h0, 0, 16'h0, 0, 1, 1, IRQ_BUILD, IRQ_BUILD, IRQ_BUILD ? 16'h0004 : 16'h0012);
    v.set_pc = 1; v.pc_val = 16'h0010; vecs.push_back(v);
    v = mk(1, 0, 0, 0, 16'h0, 0, 16'h0, 0, 1, 1, 0, 0, IRQ_BUILD ? 16'h0006 : 16'h0014);
    v.chk_saved = 1; v.e_saved = IRQ_BUILD ? 16'h0012 : 16'h0000; vecs.push_back(v);
    vecs.push_back(mk(1, 0, 0, 0, 16'h0, 0, 16'h0, 0, 1, 1, 0, 0, IRQ_BUILD ? 16'h0008 : 16'h0016));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0, 0, 16'h0, 1, 0, 1, 1, 0, IRQ_BUILD ? 16'h0012 : 16'h0000));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0, 0, 16'h0, 0, 1, 1, IRQ_BUILD, IRQ_BUILD, IRQ_BUILD ? 16'h0004 : 16'h0002));
    v = idl(1, 0, IRQ_BUILD ? 16'h0006 : 16'h0004);
    v.chk_saved = 1; v.e_saved = IRQ_BUILD ? 16'h0014 : 16'h0000; vecs.push_back(v);
    // Halted with interrupts masked stays put; after reset, a halted core wakes on irq.
    vecs.push_back(mk(1, 0, 1, 0, 16'h0, 0, 16'h0, 0, 0, 0, 0, 0, 16'h0));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0, 0, 16'h0, 0, 1, 0, 0, 0, 16'h0));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0, 0, 16'h0, 0, 0, 0, 0, 0, 16'h0000));
    vecs.push_back(idl(1, 0, 16'h0000));
    vecs.push_back(mk(1, 0, 1, 0, 16'h0, 0, 16'h0, 0, 0, 0, 0, 0, 16'h0));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0, 0, 16'h0, 0, 1, IRQ_BUILD, IRQ_BUILD, IRQ_BUILD, 16'h0004));
    v = idl(IRQ_BUILD, 0, 16'h0006);
    v.chk_saved = 1; v.e_saved = IRQ_BUILD ? 16'h0002 : 16'h0000; vecs.push_back(v);

    for (int i = 0; i < vecs.size(); i++) begin
      runCycle(vecs[i], 1'b1, $sformatf("vec%0d", i));
    end

    // Randomized traffic against the model, starting from a clean reset.
    for (int i = 0; i < 800; i++) begin
      v = mk(($urandom_range(0, 39) != 0) && (i != 0),
             $urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0,
             $urandom_range(0, 7) == 0, 16'($urandom),
             $urandom_range(0, 5) == 0, 16'($urandom),
             $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
             0, 0, 0, 16'h0);
      if ($urandom_range(0, 19) == 0) begin
        v.set_pc = 1;
        v.pc_val = ($urandom_range(0, 1) != 0) ? 16'hFFFE : 16'($urandom);
      end
      runCycle(v, 1'b0, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
